// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF sync, counter debounce, rise detect and
// sticky event flags for 4 raw board inputs.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   raw_in      raw asynchronous board inputs, bit i = channel i
//   clr_we      clear strobe for sticky flags
//   clr_mask    channels cleared when clr_we=1
//   btn_level   debounced level per channel
//   btn_rise    one-cycle pulse on accepted 0->1 transition
//   btn_pending sticky rise flag per channel
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] raw_in,
    input  logic       clr_we,
    input  logic [3:0] clr_mask,
    output logic [3:0] btn_level,
    output logic [3:0] btn_rise,
    output logic [3:0] btn_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] cnt     [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [3:0]       accept;
    logic [3:0]       level_nxt;
    logic [3:0]       rise_nxt;
    logic [3:0]       pend_nxt;
    logic [3:0]       clr;

    // Counter only runs while the synchronized input disagrees with
    // the accepted level; reaching the terminal value accepts, so the
    // counter can never wrap.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_MAX)
                    accept[i] = 1'b1;
                else
                    cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // An accept always flips the level; it is a rise when the new
    // level is 1. Set beats clear on the sticky flag.
    always_comb begin
        level_nxt = btn_level ^ accept;
        rise_nxt  = accept & sync2;
        clr       = clr_we ? clr_mask : 4'b0000;
        pend_nxt  = (btn_pending & ~clr) | rise_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_rise    <= '0;
            btn_pending <= '0;
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
        end else begin
            sync1       <= raw_in;
            sync2       <= sync1;
            btn_level   <= level_nxt;
            btn_rise    <= rise_nxt;
            btn_pending <= pend_nxt;
            for (int i = 0; i < 4; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end

endmodule
